// File: rtl/cp0_except_pkg.sv
// Shared CP0 definitions: register addresses, exception type codes, field positions
// and write masks used by the exception collector and the timer.
package cp0_except_pkg;

    typedef logic [31:0] reg_bus_t;
    localparam reg_bus_t ZERO_WORD = 32'h0000_0000;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;
    localparam logic [4:0] CP0_EBASE    = 5'd15;

    localparam reg_bus_t EXC_INT     = 32'h0000_0001;
    localparam reg_bus_t EXC_SYSCALL = 32'h0000_0008;
    localparam reg_bus_t EXC_RI      = 32'h0000_000a;
    localparam reg_bus_t EXC_OV      = 32'h0000_000c;
    localparam reg_bus_t EXC_ERET    = 32'h0000_000e;
    localparam reg_bus_t EXC_BREAK   = 32'h0000_000f;
    localparam reg_bus_t EXC_ADE     = 32'h0000_0010;

    localparam int unsigned STATUS_IE  = 0;
    localparam int unsigned STATUS_EXL = 1;
    localparam int unsigned CAUSE_BD   = 31;

    localparam reg_bus_t STATUS_RESET = 32'h1000_0000;
    localparam reg_bus_t STATUS_WMASK = 32'h0000_ff03;
    localparam reg_bus_t CAUSE_WMASK  = 32'h0000_0300;
    localparam reg_bus_t EBASE_WMASK  = 32'hffff_f000;

    // ExcCode written into Cause[6:2] for each committed exception type.
    function automatic logic [4:0] exc_code(input reg_bus_t etype);
        logic [4:0] code;
        code = 5'd0;
        case (etype)
            EXC_INT:     code = 5'd0;
            EXC_ADE:     code = 5'd4;
            EXC_SYSCALL: code = 5'd8;
            EXC_RI:      code = 5'd10;
            EXC_OV:      code = 5'd12;
            EXC_BREAK:   code = 5'd9;
            default:     code = 5'd0;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/cp0_except_unit_timer.sv
// Count/Compare timer: free-running Count, Compare match raises a sticky timer
// interrupt that only an mtc0 to Compare clears.
module cp0_timer
    import cp0_except_pkg::*;
#(
    parameter int unsigned COUNT_STEP = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        timer_int_o
);

    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        timer_int_q, timer_int_d;

    always_comb begin
        count_d     = count_q + 32'(COUNT_STEP);
        compare_d   = compare_q;
        timer_int_d = timer_int_q;
        if (we_i && waddr_i == CP0_COUNT) begin
            count_d = wdata_i;
        end
        // A Compare write acknowledges the interrupt and beats a same-cycle match.
        if (we_i && waddr_i == CP0_COMPARE) begin
            compare_d   = wdata_i;
            timer_int_d = 1'b0;
        end else if (compare_q != ZERO_WORD && count_q == compare_q) begin
            timer_int_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q     <= ZERO_WORD;
            compare_q   <= ZERO_WORD;
            timer_int_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            compare_q   <= compare_d;
            timer_int_q <= timer_int_d;
        end
    end

    assign count_o     = count_q;
    assign compare_o   = compare_q;
    assign timer_int_o = timer_int_q;

endmodule

// File: rtl/cp0_except_unit.sv
// MEM-stage exception collector and CP0 register file: resolves exception priority,
// forwards same-cycle mtc0 writes, and commits Status/Cause/EPC/BadVAddr updates.
module cp0_except_unit
    import cp0_except_pkg::*;
#(
    parameter logic [31:0] EBASE_RESET = 32'h8000_1000,
    parameter int unsigned COUNT_STEP  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  int_i,
    input  logic [5:0]  mem_except_flags_i,
    input  logic [31:0] mem_inst_addr_i,
    input  logic        mem_in_delayslot_i,
    input  logic [31:0] mem_bad_addr_i,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr_i,
    output logic [31:0] rdata_o,
    output logic [31:0] excepttype_o,
    output logic [31:0] cp0_epc_o,
    output logic [31:0] cp0_ebase_o,
    output logic        timer_int_o
);

    reg_bus_t status_q, status_d, status_eff;
    reg_bus_t cause_q, cause_d, cause_eff;
    reg_bus_t epc_q, epc_d, epc_eff;
    reg_bus_t ebase_q, ebase_d, ebase_eff;
    reg_bus_t badvaddr_q, badvaddr_d;
    reg_bus_t count, compare;
    logic     int_pending, commit, eret;
    logic     unused_int5;

    assign unused_int5 = int_i[5];

    cp0_timer #(
        .COUNT_STEP (COUNT_STEP)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .we_i        (we_i),
        .waddr_i     (waddr_i),
        .wdata_i     (wdata_i),
        .count_o     (count),
        .compare_o   (compare),
        .timer_int_o (timer_int_o)
    );

    // Effective values merge a same-cycle mtc0 into the writable fields only.
    always_comb begin
        status_eff = status_q;
        cause_eff  = cause_q;
        epc_eff    = epc_q;
        ebase_eff  = ebase_q;
        if (we_i) begin
            case (waddr_i)
                CP0_STATUS: status_eff = (status_q & ~STATUS_WMASK) | (wdata_i & STATUS_WMASK);
                CP0_CAUSE:  cause_eff  = (cause_q & ~CAUSE_WMASK) | (wdata_i & CAUSE_WMASK);
                CP0_EPC:    epc_eff    = wdata_i;
                CP0_EBASE:  ebase_eff  = wdata_i & EBASE_WMASK;
                default: ;
            endcase
        end
    end

    assign int_pending = status_eff[STATUS_IE] && !status_eff[STATUS_EXL] &&
                         ((cause_eff[15:8] & status_eff[15:8]) != 8'h00);

    always_comb begin
        excepttype_o = ZERO_WORD;
        if (mem_inst_addr_i == ZERO_WORD) begin
            excepttype_o = ZERO_WORD;
        end else if (int_pending) begin
            excepttype_o = EXC_INT;
        end else if (mem_except_flags_i[5]) begin
            excepttype_o = EXC_ADE;
        end else if (mem_except_flags_i[0]) begin
            excepttype_o = EXC_SYSCALL;
        end else if (mem_except_flags_i[1]) begin
            excepttype_o = EXC_RI;
        end else if (mem_except_flags_i[2]) begin
            excepttype_o = EXC_OV;
        end else if (mem_except_flags_i[4]) begin
            excepttype_o = EXC_BREAK;
        end else if (mem_except_flags_i[3]) begin
            excepttype_o = EXC_ERET;
        end
    end

    assign eret   = (excepttype_o == EXC_ERET);
    assign commit = (excepttype_o != ZERO_WORD) && !eret;

    always_comb begin
        status_d   = status_eff;
        cause_d    = cause_eff;
        epc_d      = epc_eff;
        ebase_d    = ebase_eff;
        badvaddr_d = badvaddr_q;
        cause_d[15:10] = {timer_int_o, int_i[4:0]};
        if (commit) begin
            // A nested exception keeps the original return address and BD.
            if (!status_eff[STATUS_EXL]) begin
                epc_d             = mem_in_delayslot_i ? mem_inst_addr_i - 32'd4
                                                       : mem_inst_addr_i;
                cause_d[CAUSE_BD] = mem_in_delayslot_i;
            end
            status_d[STATUS_EXL] = 1'b1;
            cause_d[6:2]         = exc_code(excepttype_o);
            if (excepttype_o == EXC_ADE) begin
                badvaddr_d = mem_bad_addr_i;
            end
        end else if (eret) begin
            status_d[STATUS_EXL] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            status_q   <= STATUS_RESET;
            cause_q    <= ZERO_WORD;
            epc_q      <= ZERO_WORD;
            ebase_q    <= EBASE_RESET & EBASE_WMASK;
            badvaddr_q <= ZERO_WORD;
        end else begin
            status_q   <= status_d;
            cause_q    <= cause_d;
            epc_q      <= epc_d;
            ebase_q    <= ebase_d;
            badvaddr_q <= badvaddr_d;
        end
    end

    always_comb begin
        rdata_o = ZERO_WORD;
        case (raddr_i)
            CP0_BADVADDR: rdata_o = badvaddr_q;
            CP0_COUNT:    rdata_o = count;
            CP0_COMPARE:  rdata_o = compare;
            CP0_STATUS:   rdata_o = status_eff;
            CP0_CAUSE:    rdata_o = cause_eff;
            CP0_EPC:      rdata_o = epc_eff;
            CP0_EBASE:    rdata_o = ebase_eff;
            default:      rdata_o = ZERO_WORD;
        endcase
    end

    assign cp0_epc_o   = epc_eff;
    assign cp0_ebase_o = ebase_eff;

endmodule

// File: tb/tb_cp0_except_unit.sv
// Scoreboard bench for cp0_except_unit: stimulus queues cycle-tagged expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_cp0_except_unit;

    logic        clk;
    logic        rst;
    logic [5:0]  int_i;
    logic [5:0]  flags;
    logic [31:0] inst_addr;
    logic        ds;
    logic [31:0] bad_addr;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr;
    logic [31:0] rdata;
    logic [31:0] etype;
    logic [31:0] epc;
    logic [31:0] ebase;
    logic        timer_int;

    localparam int SEL_RDATA = 0;
    localparam int SEL_ETYPE = 1;
    localparam int SEL_EPC   = 2;
    localparam int SEL_EBASE = 3;
    localparam int SEL_TINT  = 4;

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] exp;
        string       name;
    } chk_t;

    chk_t        sb[$];
    chk_t        c;
    logic [31:0] act;
    int          cyc;
    int          n_tests;
    int          n_fail;

    cp0_except_unit #(
        .EBASE_RESET (32'h8000_1000),
        .COUNT_STEP  (1)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .int_i              (int_i),
        .mem_except_flags_i (flags),
        .mem_inst_addr_i    (inst_addr),
        .mem_in_delayslot_i (ds),
        .mem_bad_addr_i     (bad_addr),
        .we_i               (we),
        .waddr_i            (waddr),
        .wdata_i            (wdata),
        .raddr_i            (raddr),
        .rdata_o            (rdata),
        .excepttype_o       (etype),
        .cp0_epc_o          (epc),
        .cp0_ebase_o        (ebase),
        .timer_int_o        (timer_int)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every expectation tagged for this cycle is checked mid-cycle.
    initial begin
        n_tests = 0;
        n_fail  = 0;
    end
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            c = sb.pop_front();
            case (c.sel)
                SEL_RDATA: act = rdata;
                SEL_ETYPE: act = etype;
                SEL_EPC:   act = epc;
                SEL_EBASE: act = ebase;
                default:   act = {31'd0, timer_int};
            endcase
            n_tests++;
            if (c.cyc != cyc || act !== c.exp) begin
                n_fail++;
                $display("FAIL %s (cycle %0d/%0d): got %h expected %h",
                         c.name, cyc, c.cyc, act, c.exp);
            end
        end
    end

    task automatic expect_val(input int sel, input logic [31:0] exp, input string name);
        chk_t e;
        e.cyc  = cyc;
        e.sel  = sel;
        e.exp  = exp;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flags     = 6'd0;
        inst_addr = 32'd0;
        ds        = 1'b0;
        we        = 1'b0;
        waddr     = 5'd0;
        wdata     = 32'd0;
    endtask

    task automatic inst(input logic [31:0] a, input logic [5:0] f, input logic d);
        inst_addr = a;
        flags     = f;
        ds        = d;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        we    = 1'b1;
        waddr = a;
        wdata = d;
    endtask

    initial begin
        rst      = 1'b0;
        int_i    = 6'd0;
        bad_addr = 32'd0;
        raddr    = 5'd0;
        idle();
        step();
        step();

        // Reset state and release.
        raddr = 5'd12;
        expect_val(SEL_RDATA, 32'h1000_0000, "reset_status");
        expect_val(SEL_TINT, 32'd0, "reset_timer_int");
        #1;
        n_tests++;
        if (rdata !== 32'h1000_0000) begin
            n_fail++;
            $display("FAIL direct_reset_status: got %h", rdata);
        end
        step();
        rst   = 1'b1;
        raddr = 5'd15;
        expect_val(SEL_RDATA, 32'h8000_1000, "reset_ebase_read");
        expect_val(SEL_EBASE, 32'h8000_1000, "reset_ebase_out");
        for (int i = 1; i <= 5; i++) begin
            step();
            raddr = 5'd9;
            expect_val(SEL_RDATA, 32'(i), "count_after_release");
        end
        step();

        // Syscall, not in delay slot.
        inst(32'hBFC0_0100, 6'h01, 1'b0);
        expect_val(SEL_ETYPE, 32'h08, "syscall_type");
        #1;
        n_tests++;
        if (etype !== 32'h08) begin
            n_fail++;
            $display("FAIL direct_syscall_type: got %h", etype);
        end
        step();
        idle();
        raddr = 5'd14;
        expect_val(SEL_RDATA, 32'hBFC0_0100, "syscall_epc_read");
        expect_val(SEL_EPC, 32'hBFC0_0100, "syscall_epc_out");
        step();
        raddr = 5'd13;
        expect_val(SEL_RDATA, 32'h0000_0020, "syscall_cause");
        step();
        raddr = 5'd12;
        expect_val(SEL_RDATA, 32'h1000_0002, "syscall_exl_set");
        inst(32'h8000_0000, 6'h08, 1'b0);
        expect_val(SEL_ETYPE, 32'h0e, "eret1_type");
        step();
        idle();
        expect_val(SEL_RDATA, 32'h1000_0000, "eret1_exl_clear");
        step();

        // Overflow in a delay slot, then eret.
        inst(32'h8000_0010, 6'h04, 1'b1);
        expect_val(SEL_ETYPE, 32'h0c, "ov_ds_type");
        step();
        idle();
        raddr = 5'd13;
        expect_val(SEL_EPC, 32'h8000_000C, "ov_ds_epc");
        expect_val(SEL_RDATA, 32'h8000_0030, "ov_ds_cause_bd");
        step();
        inst(32'h8000_0014, 6'h08, 1'b0);
        expect_val(SEL_ETYPE, 32'h0e, "eret2_type");
        expect_val(SEL_EPC, 32'h8000_000C, "eret2_epc");
        #1;
        n_tests++;
        if (epc !== 32'h8000_000C) begin
            n_fail++;
            $display("FAIL direct_eret2_epc: got %h", epc);
        end
        step();
        idle();
        raddr = 5'd12;
        expect_val(SEL_RDATA, 32'h1000_0000, "eret2_exl_clear");
        step();

        // Timer interrupt.
        mtc0(5'd12, 32'h0000_FF01);
        expect_val(SEL_RDATA, 32'h1000_FF01, "status_fwd");
        step();
        mtc0(5'd11, 32'd10);
        step();
        mtc0(5'd9, 32'd5);
        step();
        idle();
        for (int i = 0; i < 5; i++) begin
            raddr = 5'd9;
            expect_val(SEL_RDATA, 32'(5 + i), "count_reload");
            expect_val(SEL_TINT, 32'd0, "timer_not_yet");
            step();
        end
        expect_val(SEL_RDATA, 32'd10, "count_hits_compare");
        expect_val(SEL_TINT, 32'd0, "timer_on_match_cycle");
        step();
        expect_val(SEL_TINT, 32'd1, "timer_raised");
        inst(32'h8000_0100, 6'h00, 1'b0);
        expect_val(SEL_ETYPE, 32'h00, "ip_not_yet_latched");
        step();
        inst(32'h8000_0104, 6'h00, 1'b0);
        expect_val(SEL_ETYPE, 32'h01, "timer_interrupt_taken");
        step();
        idle();
        mtc0(5'd11, 32'd0);
        raddr = 5'd12;
        expect_val(SEL_RDATA, 32'h1000_FF03, "int_exl_set");
        expect_val(SEL_EPC, 32'h8000_0104, "int_epc");
        expect_val(SEL_TINT, 32'd1, "timer_before_clear");
        step();
        idle();
        expect_val(SEL_TINT, 32'd0, "timer_cleared");

        // Interrupt beats sync flags; bubble beats everything.
        mtc0(5'd12, 32'h0000_FF01);
        int_i = 6'h01;
        step();
        idle();
        inst(32'h0000_0000, 6'h21, 1'b0);
        expect_val(SEL_ETYPE, 32'h00, "bubble_suppresses");
        step();
        inst(32'h8000_0200, 6'h21, 1'b0);
        int_i = 6'h00;
        expect_val(SEL_ETYPE, 32'h01, "int_beats_flags");
        step();

        // Nested exceptions while EXL=1.
        inst(32'h8000_0300, 6'h04, 1'b0);
        expect_val(SEL_ETYPE, 32'h0c, "nested_ov_type");
        step();
        inst(32'h8000_0400, 6'h20, 1'b0);
        bad_addr = 32'h1234_5679;
        raddr    = 5'd13;
        expect_val(SEL_ETYPE, 32'h10, "ade_type");
        expect_val(SEL_EPC, 32'h8000_0200, "nested_epc_kept");
        expect_val(SEL_RDATA, 32'h0000_0030, "nested_exccode");
        step();
        inst(32'h8000_0500, 6'h10, 1'b0);
        raddr = 5'd8;
        expect_val(SEL_ETYPE, 32'h0f, "break_type");
        expect_val(SEL_RDATA, 32'h1234_5679, "badvaddr");
        step();
        idle();
        mtc0(5'd12, 32'h0000_FF00);
        raddr = 5'd13;
        expect_val(SEL_RDATA, 32'h0000_0024, "break_exccode");
        step();

        // mtc0 EPC in the same cycle as an exception.
        mtc0(5'd14, 32'hDEAD_BEEF);
        inst(32'h8000_0600, 6'h02, 1'b0);
        expect_val(SEL_ETYPE, 32'h0a, "ri_type");
        expect_val(SEL_EPC, 32'hDEAD_BEEF, "epc_fwd");
        step();
        idle();
        mtc0(5'd15, 32'h9000_0ABC);
        expect_val(SEL_EPC, 32'h8000_0600, "exception_wins_epc");
        expect_val(SEL_RDATA, 32'h0000_0028, "ri_exccode");
        expect_val(SEL_EBASE, 32'h9000_0000, "ebase_fwd");
        step();
        mtc0(5'd3, 32'hFFFF_FFFF);
        raddr = 5'd15;
        expect_val(SEL_RDATA, 32'h9000_0000, "ebase_stored");
        step();
        idle();
        raddr = 5'd3;
        expect_val(SEL_RDATA, 32'h0000_0000, "unmapped_reads_zero");
        #1;
        n_tests++;
        if (rdata !== 32'h0000_0000) begin
            n_fail++;
            $display("FAIL direct_unmapped_read: got %h", rdata);
        end
        step();

        // Asynchronous reset mid-operation.
        rst   = 1'b0;
        raddr = 5'd14;
        expect_val(SEL_RDATA, 32'h0000_0000, "async_reset_epc");
        expect_val(SEL_EBASE, 32'h8000_1000, "async_reset_ebase");
        #1;
        n_tests++;
        if (rdata !== 32'h0000_0000) begin
            n_fail++;
            $display("FAIL direct_async_reset_epc: got %h", rdata);
        end
        step();
        rst = 1'b1;
        step();
        step();

        while (sb.size() > 0) begin
            c = sb.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL %s: never checked, expected %h", c.name, c.exp);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
